// File: rtl/pixel_status_pkg.sv
// Shared definitions for the pixel status input port.
//   REG_*        : word offsets of the Avalon-MM register map
//   edge_type_e  : which in_port transition counts as an event
package pixel_status_pkg;

  localparam logic [1:0] REG_DATA     = 2'd0;
  localparam logic [1:0] REG_IRQ_MASK = 2'd1;
  localparam logic [1:0] REG_EDGE_CAP = 2'd2;
  localparam logic [1:0] REG_EVT_CNT  = 2'd3;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_ANY  = 2'd2
  } edge_type_e;

endpackage

// File: rtl/pixel_status_sync_edge.sv
// Synchronizer chain plus edge detector for the asynchronous status flag.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   async_in     : raw flag from the display engine
//   level        : synchronized level (last synchronizer stage)
//   edge_pulse   : one-cycle pulse on a qualifying transition of level
// Parameters: SYNC_STAGES (2..4), EDGE_TYPE (rise / fall / any).
module pixel_status_sync_edge
  import pixel_status_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter edge_type_e  EDGE_TYPE   = EDGE_RISE
) (
  input  logic clk,
  input  logic reset_n,
  input  logic async_in,
  output logic level,
  output logic edge_pulse
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   dly_q, dly_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
    dly_d  = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      dly_q  <= dly_d;
    end
  end

  assign level = sync_q[SYNC_STAGES-1];

  always_comb begin
    edge_pulse = 1'b0;
    case (EDGE_TYPE)
      EDGE_RISE: edge_pulse = level & ~dly_q;
      EDGE_FALL: edge_pulse = ~level & dly_q;
      default:   edge_pulse = level ^ dly_q;
    endcase
  end

endmodule

// File: rtl/ssd_pixel_status_in.sv
// Avalon-MM PIO slave reporting the display engine's pixel-done flag.
// Register map: 0 DATA (RO level), 1 IRQ_MASK (RW bit0),
//               2 EDGE_CAPTURE (W1C bit0), 3 EVENT_COUNT (RO, write clears).
// Ports:
//   clk, reset_n            : clock, asynchronous active-low reset
//   address, chipselect,
//   read_n, write_n,
//   writedata               : Avalon-MM slave request
//   readdata                : registered read data, latency 1
//   in_port                 : asynchronous status flag
//   irq                     : registered level interrupt (capture & mask)
// Build option: define PIXEL_STATUS_EVENT_COUNT_EN to include the event
// counter; otherwise offset 3 reads 0 and ignores writes.
module ssd_pixel_status_in
  import pixel_status_pkg::*;
#(
  parameter int unsigned EDGE_TYPE   = 0,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned COUNT_W     = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        read_n,
  input  logic        write_n,
  input  logic [31:0] writedata,
  input  logic        in_port,
  output logic [31:0] readdata,
  output logic        irq
);

  logic level;
  logic edge_pulse;
  logic rd_en;
  logic wr_en;

  pixel_status_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .EDGE_TYPE   (edge_type_e'(EDGE_TYPE[1:0]))
  ) u_sync_edge (
    .clk        (clk),
    .reset_n    (reset_n),
    .async_in   (in_port),
    .level      (level),
    .edge_pulse (edge_pulse)
  );

  assign rd_en = chipselect & ~read_n;
  assign wr_en = chipselect & ~write_n;

  // Only bit 0 of writedata is meaningful in any register.
  logic unused_wdata;
  assign unused_wdata = ^writedata[31:1];

  logic        mask_q, mask_d;
  logic        cap_q, cap_d;
  logic        irq_q, irq_d;
  logic [31:0] readdata_q, readdata_d;
  logic [31:0] cnt_rd;

`ifdef PIXEL_STATUS_EVENT_COUNT_EN
  logic [COUNT_W-1:0] cnt_q, cnt_d;

  // An edge coinciding with a clear yields 1: the clear empties the
  // counter and the edge is still counted in the same cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (edge_pulse) begin
      if (wr_en && address == REG_EVT_CNT) cnt_d = COUNT_W'(1);
      else if (!(&cnt_q))                  cnt_d = cnt_q + COUNT_W'(1);
    end else if (wr_en && address == REG_EVT_CNT) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign cnt_rd = 32'(cnt_q);
`else
  localparam int unsigned UNUSED_COUNT_W = COUNT_W;
  assign cnt_rd = '0;
`endif

  always_comb begin
    mask_d = mask_q;
    if (wr_en && address == REG_IRQ_MASK) mask_d = writedata[0];

    // Set has priority over a simultaneous W1C clear.
    cap_d = cap_q;
    if (edge_pulse)                                             cap_d = 1'b1;
    else if (wr_en && address == REG_EDGE_CAP && writedata[0]) cap_d = 1'b0;

    irq_d = cap_q & mask_q;

    readdata_d = readdata_q;
    if (rd_en) begin
      case (address)
        REG_DATA:     readdata_d = 32'(level);
        REG_IRQ_MASK: readdata_d = 32'(mask_q);
        REG_EDGE_CAP: readdata_d = 32'(cap_q);
        default:      readdata_d = cnt_rd;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q     <= 1'b0;
      cap_q      <= 1'b0;
      irq_q      <= 1'b0;
      readdata_q <= '0;
    end else begin
      mask_q     <= mask_d;
      cap_q      <= cap_d;
      irq_q      <= irq_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_ssd_pixel_status_in.sv
module tb_ssd_pixel_status_in;

  localparam int unsigned S   = 2;
  localparam int unsigned CW  = 4;
  localparam int unsigned ET  = 0;
  localparam int unsigned CMAX = (1 << CW) - 1;
`ifdef PIXEL_STATUS_EVENT_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        read_n;
  logic        write_n;
  logic [31:0] writedata;
  logic        in_port;
  logic [31:0] readdata;
  logic        irq;

  ssd_pixel_status_in #(
    .EDGE_TYPE   (ET),
    .SYNC_STAGES (S),
    .COUNT_W     (CW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .read_n     (read_n),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (readdata),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: in_port samples per clock kept as a history; the
  // register contents are plain variables updated from the bus rules.
  bit          hist[$];
  bit          m_mask, m_cap, m_irq;
  int unsigned m_cnt;
  logic [31:0] exp_q[$];

  function automatic bit qualifies(input bit cur, input bit prev);
    case (ET)
      0:       return cur & ~prev;
      1:       return ~cur & prev;
      default: return cur ^ prev;
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist.delete();
      for (int i = 0; i < int'(S) + 2; i++) hist.push_back(1'b0);
      m_mask = 1'b0; m_cap = 1'b0; m_irq = 1'b0; m_cnt = 0;
      exp_q.delete();
    end else begin
      bit ev, rd, wr;
      logic [31:0] rv;
      hist.push_front(in_port);
      void'(hist.pop_back());
      // Level visible on the bus lags in_port by S samples; an event is
      // a qualifying change between consecutive visible levels.
      ev = qualifies(hist[S], hist[S+1]);
      rd = chipselect && !read_n;
      wr = chipselect && !write_n;
      if (rd) begin
        case (address)
          2'd0:    rv = 32'(hist[S]);
          2'd1:    rv = 32'(m_mask);
          2'd2:    rv = 32'(m_cap);
          default: rv = CNT_EN ? 32'(m_cnt) : 32'd0;
        endcase
        exp_q.push_back(rv);
      end
      m_irq = m_cap & m_mask;
      if (wr && address == 2'd1) m_mask = writedata[0];
      if (ev) m_cap = 1'b1;
      else if (wr && address == 2'd2 && writedata[0]) m_cap = 1'b0;
      if (CNT_EN) begin
        if (wr && address == 2'd3) m_cnt = ev ? 1 : 0;
        else if (ev && m_cnt < CMAX) m_cnt = m_cnt + 1;
      end
    end
  end

  // Monitor: readdata holds between reads; a completed read updates the
  // expected value from the scoreboard queue.
  logic [31:0] last_rd = '0;
  always @(negedge clk) begin
    if (!reset_n) last_rd = '0;
    else if (exp_q.size() > 0) last_rd = exp_q.pop_front();
    check("readdata", readdata, last_rd);
    check("irq", 32'(irq), 32'(m_irq));
  end

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a);
    chipselect = 1'b1; read_n = 1'b0; address = a;
    @(negedge clk);
    chipselect = 1'b0; read_n = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic read_all();
    for (int a = 0; a < 4; a++) bus_read(2'(a));
    idle(1);
  endtask

  initial begin
    reset_n = 1'b0; chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1;
    address = '0; writedata = '0; in_port = 1'b0;
    idle(3);
    #2 reset_n = 1'b1;
    @(negedge clk);
    read_all();

    // Level read
    in_port = 1'b1;
    idle(S);
    bus_read(2'd0);
    idle(2);

    // Edge plus irq, then W1C
    in_port = 1'b0;
    bus_write(2'd2, 32'h1);
    idle(S + 2);
    bus_write(2'd1, 32'h1);
    in_port = 1'b1;
    idle(S + 3);
    bus_read(2'd2);
    bus_write(2'd2, 32'h1);
    idle(3);

    // Set/clear collision
    in_port = 1'b0;
    idle(S + 3);
    in_port = 1'b1;
    idle(S);
    bus_write(2'd2, 32'h1);
    bus_read(2'd2);
    idle(3);

    // Counter saturation and clear/edge collision
    in_port = 1'b0;
    idle(S + 2);
    bus_write(2'd3, 32'h0);
    for (int i = 0; i < 20; i++) begin
      in_port = 1'b1; idle(2);
      in_port = 1'b0; idle(2);
    end
    idle(S + 2);
    bus_read(2'd3);
    in_port = 1'b1;
    idle(S);
    bus_write(2'd3, 32'h0);
    bus_read(2'd3);
    bus_read(2'd2);
    idle(2);

    // Asynchronous reset mid-operation
    @(negedge clk);
    #2 reset_n = 1'b0;
    idle(2);
    #2 reset_n = 1'b1;
    in_port = 1'b0;
    @(negedge clk);
    read_all();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      int unsigned op;
      if ($urandom_range(3) == 0) in_port = ~in_port;
      op = $urandom_range(5);
      chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1;
      address = 2'($urandom_range(3));
      writedata = $urandom;
      if (op == 1 || op == 2) begin chipselect = 1'b1; read_n = 1'b0; end
      else if (op == 3) begin chipselect = 1'b1; write_n = 1'b0; end
      else if (op == 4) begin read_n = 1'b0; write_n = 1'b0; end
      @(negedge clk);
    end
    chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1;
    idle(2);
    read_all();
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
